// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
//   Types and helpers shared by the fetch stage and its fetch queue.
//   - fetch_entry_s : one buffered fetch (PC, instruction word, prediction)
//   - PC_STEP       : sequential fetch increment (one 32-bit instruction)
//   - align_pc()    : clears the two low address bits of a redirect target
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_s;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : fetch_unit_pkg

// File: rtl/fetch_unit_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Circular FIFO of fetch_entry_s with push, pop and flush.
//   Ports:
//     clk_i, reset_i   clock and asynchronous active-high reset
//     push_i           write wdata_i at the tail (caller guarantees room,
//                      or a simultaneous pop when full)
//     pop_i            advance the head (caller guarantees non-empty)
//     flush_i          empty the queue; overrides push and pop
//     wdata_i          entry to write
//     head_o           entry at the read pointer
//     count_o          occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  fetch_entry_s               wdata_i,
    output fetch_entry_s               head_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_s     mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    logic do_push;
    logic do_pop;

    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i;

    // Pointers are exactly PW bits wide and DEPTH is a power of two, so the
    // natural binary overflow implements the modulo-DEPTH wrap.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            // Push and pop together leave the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset: contents are only observed while
    // the occupancy says they are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Front-end fetch stage. Holds the fetch PC, presents it to the branch
//   predictor and instruction memory, chooses the next PC and buffers each
//   fetched instruction with its prediction for decode.
//   Ports:
//     clk_i, reset_i          clock, asynchronous active-high reset
//     pred_pc_o               current fetch PC to the predictor
//     pred_taken_i/target_i   predictor result for pred_pc_o
//     imem_req_o/addr_o       fetch request and address (= pred_pc_o)
//     imem_rdata_i            instruction word, same-cycle read
//     redirect_i/redirect_pc_i  resolution redirect (highest priority)
//     fq_valid_o/ready_i      head handshake to decode
//     fq_pc_o/instr_o/pred_taken_o/pred_target_o  head entry fields
//     fq_count_o              queue occupancy
// ---------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    output logic [31:0]                 pred_pc_o,
    input  logic                        pred_taken_i,
    input  logic [31:0]                 pred_target_i,
    output logic                        imem_req_o,
    output logic [31:0]                 imem_addr_o,
    input  logic [31:0]                 imem_rdata_i,
    input  logic                        redirect_i,
    input  logic [31:0]                 redirect_pc_i,
    output logic                        fq_valid_o,
    input  logic                        fq_ready_i,
    output logic [31:0]                 fq_pc_o,
    output logic [31:0]                 fq_instr_o,
    output logic                        fq_pred_taken_o,
    output logic [31:0]                 fq_pred_target_o,
    output logic [$clog2(FQ_DEPTH):0]   fq_count_o
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [31:0]    pc_q, pc_d;
    logic [31:0]    next_pc;
    logic           push;
    logic           pop;
    logic           has_room;
    fetch_entry_s   wr_entry;
    fetch_entry_s   head_entry;
    logic [CW-1:0]  count;

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_i),
        .wdata_i (wr_entry),
        .head_o  (head_entry),
        .count_o (count)
    );

    // Valid is masked during a redirect so decode never takes an entry that
    // is about to be flushed.
    assign fq_valid_o = (count != '0) & ~redirect_i;
    assign pop        = fq_valid_o & fq_ready_i;
    assign has_room   = (count < CW'(FQ_DEPTH));
    // A full queue can still accept a fetch when decode drains the head in
    // the same cycle.
    assign push       = ~reset_i & ~redirect_i & (has_room | pop);

    assign next_pc = pred_taken_i ? pred_target_i : pc_q + PC_STEP;

    assign wr_entry = '{
        pc:          pc_q,
        instr:       imem_rdata_i,
        pred_taken:  pred_taken_i,
        pred_target: next_pc
    };

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = align_pc(redirect_pc_i);
        end else if (push) begin
            pc_d = next_pc;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pred_pc_o        = pc_q;
    assign imem_addr_o      = pc_q;
    assign imem_req_o       = push;
    assign fq_pc_o          = head_entry.pc;
    assign fq_instr_o       = head_entry.instr;
    assign fq_pred_taken_o  = head_entry.pred_taken;
    assign fq_pred_target_o = head_entry.pred_target;
    assign fq_count_o       = count;

endmodule : fetch_unit
